// File: rtl/i2c_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module : i2c_txn_sequencer
// Queues I2C byte commands, drives the master one transaction at a time and
// returns read data / status through a one-entry response slot.
// Rev    : 1.0  initial release
// ============================================================================
module i2c_txn_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_rw,
   input  logic [6:0]                 cmd_addr,
   input  logic [7:0]                 cmd_wdata,
   output logic                       m_initiate,
   output logic                       m_rw,
   output logic [6:0]                 m_targetAddr,
   output logic [7:0]                 m_writeData,
   output logic                       m_abort,
   input  logic                       m_done,
   input  logic                       m_ack_err,
   input  logic [7:0]                 m_readData,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [7:0]                 rsp_rdata,
   output logic                       rsp_err,
   output logic                       rsp_timeout,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       idle
);
   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam int c_tmr_w = $clog2(TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);
   localparam logic [c_tmr_w-1:0] c_last = c_tmr_w'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t r_state, w_state_nxt;

   logic [15:0]        r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wptr, r_rptr;
   logic [c_cnt_w-1:0] r_count;
   logic [c_tmr_w-1:0] r_timer;
   logic               r_m_rw;
   logic [6:0]         r_m_addr;
   logic [7:0]         r_m_wdata;
   logic               r_rsp_valid, r_rsp_err, r_rsp_timeout;
   logic [7:0]         r_rsp_rdata;
   logic               w_push, w_pop, w_expire;

   assign cmd_ready = (r_count != c_full);
   assign w_push    = cmd_valid & cmd_ready;
   // Last WAIT cycle: cycle TIMEOUT counted from the initiate pulse
   assign w_expire  = (r_timer == c_last);

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0 && !r_rsp_valid) begin
               w_pop       = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD:  w_state_nxt = S_START;
         S_START: w_state_nxt = S_WAIT;
         S_WAIT:  if (m_done || w_expire) w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Storage needs no reset: only entries written since reset are ever popped
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= {cmd_rw, cmd_addr, cmd_wdata};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
         if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
         r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_timer       <= '0;
         r_m_rw        <= 1'b0;
         r_m_addr      <= '0;
         r_m_wdata     <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (w_pop) {r_m_rw, r_m_addr, r_m_wdata} <= r_mem[r_rptr];

         if (r_state == S_START)     r_timer <= '0;
         else if (r_state == S_WAIT) r_timer <= r_timer + c_tmr_w'(1);

         // Completion takes priority over a timeout landing on the same cycle
         if (r_state == S_WAIT && m_done) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_m_rw ? m_readData : 8'h00;
            r_rsp_err     <= m_ack_err;
            r_rsp_timeout <= 1'b0;
         end else if (r_state == S_WAIT && w_expire) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= 8'h00;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b1;
         end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid   <= 1'b0;
         end
      end
   end

   assign m_initiate   = (r_state == S_START);
   assign m_abort      = (r_state == S_WAIT) && w_expire && !m_done;
   assign m_rw         = r_m_rw;
   assign m_targetAddr = r_m_addr;
   assign m_writeData  = r_m_wdata;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_err      = r_rsp_err;
   assign rsp_timeout  = r_rsp_timeout;
   assign fifo_count   = r_count;
   assign idle         = (r_state == S_IDLE) && (r_count == '0) && !r_rsp_valid;

endmodule
`default_nettype wire
